// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush sequencer for the five-stage pipeline (load-use,
//           branch, multi-cycle MDU, debug halt). Optional macro:
//           STALL_COUNTER_EN enables the stall-cycle performance counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 4,
   parameter int MDU_LAT    = 4,
   parameter int CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  branch_taken,
   input  logic                  mdu_start,
   input  logic                  halt_req,
   input  logic                  resume,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_write,
   output logic                  idex_flush,
   output logic                  exmem_write,
   output logic                  exmem_flush,
   output logic                  busy,
   output logic                  halted,
   output logic [15:0]           stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MDU_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_MDU_LOAD = CNT_W'(MDU_LAT - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use;

   assign load_use = ex_is_load &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_flush  = 1'b0;
      exmem_write = 1'b1;
      exmem_flush = 1'b0;
      busy        = 1'b0;
      halted      = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (branch_taken) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (mdu_start) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_write  = 1'b0;
               exmem_write = 1'b0;
               exmem_flush = 1'b1;
               busy        = 1'b1;
               cnt_d       = C_MDU_LOAD;
               state_d     = ST_MDU_WAIT;
            end else if (load_use) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_flush = 1'b1;
            end else if (halt_req) begin
               state_d = ST_HALT;
            end
         end
         ST_MDU_WAIT: begin
            // Start cycle already counted as one frozen cycle, so the
            // counter was loaded with MDU_LAT-1.
            if (cnt_q != '0) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_write  = 1'b0;
               exmem_write = 1'b0;
               exmem_flush = 1'b1;
               busy        = 1'b1;
               cnt_d       = cnt_q - C_CNT_ONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
            if (resume) begin
               state_d = ST_RUN;
            end else begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_write  = 1'b0;
               exmem_write = 1'b0;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase

      // Reset forces the flush pattern without waiting for a clock edge.
      if (!rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_write  = 1'b0;
         idex_flush  = 1'b1;
         exmem_write = 1'b0;
         exmem_flush = 1'b1;
         busy        = 1'b0;
         halted      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef STALL_COUNTER_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_write && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= 16'h0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

   // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
   //  exmem_write, exmem_flush, busy, halted}
   localparam logic [8:0] C_RUN  = 9'b1_1_0_1_0_1_0_0_0;
   localparam logic [8:0] C_RST  = 9'b0_0_1_0_1_0_1_0_0;
   localparam logic [8:0] C_BR   = 9'b1_1_1_1_1_1_0_0_0;
   localparam logic [8:0] C_MDU  = 9'b0_0_0_0_0_0_1_1_0;
   localparam logic [8:0] C_LU   = 9'b0_0_0_1_1_1_0_0_0;
   localparam logic [8:0] C_HALT = 9'b0_0_0_0_0_0_0_0_1;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_is_load;
   logic       branch_taken, mdu_start, halt_req, resume;
   logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
   logic       exmem_write, exmem_flush, busy, halted;
   logic [15:0] stall_cycles;
   logic [8:0]  outs;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .REG_ADDR_W (4),
      .MDU_LAT    (4),
      .CNT_W      (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .ex_is_load   (ex_is_load),
      .ex_rd        (ex_rd),
      .branch_taken (branch_taken),
      .mdu_start    (mdu_start),
      .halt_req     (halt_req),
      .resume       (resume),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .idex_write   (idex_write),
      .idex_flush   (idex_flush),
      .exmem_write  (exmem_write),
      .exmem_flush  (exmem_flush),
      .busy         (busy),
      .halted       (halted),
      .stall_cycles (stall_cycles)
   );

   assign outs = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                  exmem_write, exmem_flush, busy, halted};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then driven
   // and outputs sampled 1 time unit later.
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      id_rs1 = 4'h0; id_rs2 = 4'h0; ex_rd = 4'h0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
      branch_taken = 1'b0; mdu_start = 1'b0; halt_req = 1'b0; resume = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      #3;
      chk("reset_outs", {7'd0, outs}, {7'd0, C_RST});
      chk("reset_stall", stall_cycles, 16'h0000);
      #9 rst = 1'b1;

      next_cycle(); #1;
      chk("run_idle", {7'd0, outs}, {7'd0, C_RUN});

      // Load-use on rs2
      next_cycle();
      ex_is_load = 1'b1; ex_rd = 4'h3; id_rs2 = 4'h3; id_uses_rs2 = 1'b1;
      #1 chk("lu_rs2", {7'd0, outs}, {7'd0, C_LU});
      next_cycle(); idle();
      #1 chk("lu_after", {7'd0, outs}, {7'd0, C_RUN});
`ifdef STALL_COUNTER_EN
      chk("stall_after_lu", stall_cycles, 16'd1);
`endif

      // rs1 match but not used: no hazard
      next_cycle();
      ex_is_load = 1'b1; ex_rd = 4'h5; id_rs1 = 4'h5; id_uses_rs1 = 1'b0;
      #1 chk("lu_rs1_unused", {7'd0, outs}, {7'd0, C_RUN});
      id_uses_rs1 = 1'b1;
      #1 chk("lu_rs1_used", {7'd0, outs}, {7'd0, C_LU});
      ex_is_load = 1'b0;
      #1 chk("no_load", {7'd0, outs}, {7'd0, C_RUN});
      ex_is_load = 1'b1;

      // Branch beats load-use
      next_cycle();
      ex_is_load = 1'b1; ex_rd = 4'h7; id_rs1 = 4'h7; id_uses_rs1 = 1'b1;
      branch_taken = 1'b1;
      #1 chk("br_over_lu", {7'd0, outs}, {7'd0, C_BR});
      next_cycle(); idle();
      #1 chk("br_after", {7'd0, outs}, {7'd0, C_RUN});

      // MDU: four frozen cycles, branch during wait ignored
      next_cycle();
      mdu_start = 1'b1;
      #1 chk("mdu_c1", {7'd0, outs}, {7'd0, C_MDU});
      next_cycle(); idle(); branch_taken = 1'b1;
      #1 chk("mdu_c2_br", {7'd0, outs}, {7'd0, C_MDU});
      next_cycle(); idle();
      #1 chk("mdu_c3", {7'd0, outs}, {7'd0, C_MDU});
      next_cycle();
      #1 chk("mdu_c4", {7'd0, outs}, {7'd0, C_MDU});
      next_cycle();
      #1 chk("mdu_c5", {7'd0, outs}, {7'd0, C_RUN});
      next_cycle();
      #1 chk("mdu_c6", {7'd0, outs}, {7'd0, C_RUN});
`ifdef STALL_COUNTER_EN
      chk("stall_after_mdu", stall_cycles, 16'd6);
`endif

      // Halt: request cycle is normal, then frozen
      next_cycle();
      halt_req = 1'b1;
      #1 chk("halt_req_cycle", {7'd0, outs}, {7'd0, C_RUN});
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         #1 chk("halted", {7'd0, outs}, {7'd0, C_HALT});
      end
`ifdef STALL_COUNTER_EN
      chk("stall_in_halt", stall_cycles, 16'd6);
`endif
      resume = 1'b1;
      #1 chk("resume_writes", {9'd0, outs[8:2]}, {9'd0, C_RUN[8:2]});
      next_cycle(); idle();
      #1 chk("after_resume", {7'd0, outs}, {7'd0, C_RUN});

      // Load-use outranks halt_req
      next_cycle();
      ex_is_load = 1'b1; ex_rd = 4'h9; id_rs2 = 4'h9; id_uses_rs2 = 1'b1;
      halt_req = 1'b1;
      #1 chk("lu_over_halt", {7'd0, outs}, {7'd0, C_LU});
      next_cycle(); idle();
      #1 chk("lu_over_halt_next", {7'd0, outs}, {7'd0, C_RUN});
`ifdef STALL_COUNTER_EN
      chk("stall_final", stall_cycles, 16'd7);
`endif

      // Reset two cycles into an MDU wait
      next_cycle();
      mdu_start = 1'b1;
      #1 chk("mdu2_c1", {7'd0, outs}, {7'd0, C_MDU});
      next_cycle(); idle();
      #1 chk("mdu2_c2", {7'd0, outs}, {7'd0, C_MDU});
      rst = 1'b0;
      #1 chk("async_rst", {7'd0, outs}, {7'd0, C_RST});
      chk("async_rst_stall", stall_cycles, 16'h0000);
      #2 rst = 1'b1;
      next_cycle();
      #1 chk("post_rst_run", {7'd0, outs}, {7'd0, C_RUN});
      next_cycle();
      #1 chk("post_rst_run2", {7'd0, outs}, {7'd0, C_RUN});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 16-bit five-stage pipeline. It drives the writeEnable and flush inputs of the PC register and of the IF/ID, ID/EX and EX/MEM stage buffers. It resolves load-use hazards, taken branches, multi-cycle multiply/divide (MDU) operations and an external halt/resume debug request. All stage buffers and the PC use the shared register module; this block only sequences them.

Parameters:
REG_ADDR_W, 4, width of register-file index fields
MDU_LAT, 4, total stall cycles for one MDU operation (legal range 1..255)
CNT_W, 8, width of the MDU down-counter (must hold MDU_LAT-1)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-low reset
id_rs1  input  REG_ADDR_W  source register 1 of the instruction in ID
id_rs2  input  REG_ADDR_W  source register 2 of the instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_is_load  input  1  EX instruction is a load
ex_rd  input  REG_ADDR_W  destination register of the EX instruction
branch_taken  input  1  EX resolved a taken branch or jump this cycle
mdu_start  input  1  EX holds a multi-cycle MDU op, first cycle
halt_req  input  1  debug halt request (level)
resume  input  1  single-cycle pulse that leaves HALT
pc_write  output  1  PC register writeEnable
ifid_write  output  1  IF/ID writeEnable
ifid_flush  output  1  IF/ID flush (active-high from this block)
idex_write  output  1  ID/EX writeEnable
idex_flush  output  1  ID/EX flush, inserts a bubble
exmem_write  output  1  EX/MEM writeEnable
exmem_flush  output  1  EX/MEM flush
busy  output  1  MDU stall in progress
halted  output  1  controller is in HALT
stall_cycles  output  16  stall-cycle performance counter (see Optional Feature)

Behaviour:
- State machine states: RUN, MDU_WAIT, HALT. Register CNT_W-bit counter cnt.
- While rst is low: state=RUN, cnt=0, all *_write=0, all *_flush=1, busy=0, halted=0, stall_cycles=0. These values apply asynchronously.
- Outputs are Mealy: they react in the same cycle as the inputs.
- Default in RUN: all *_write=1, all *_flush=0.
- RUN priority is branch_taken > mdu_start > load-use > halt_req. Only the highest-priority active event acts.
- branch_taken: ifid_flush=1, idex_flush=1; writes stay 1 so the PC loads the target. Next state is RUN.
- mdu_start: pc_write, ifid_write, idex_write and exmem_write are all 0; exmem_flush=1; busy=1. Load cnt=MDU_LAT-1. Next state is MDU_WAIT.
- Load-use hazard = ex_is_load & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - On a hazard: pc_write=0, ifid_write=0, idex_flush=1. Next state is RUN (exactly one bubble).
- halt_req with no higher event: outputs are the RUN default this cycle. Next state is HALT.
- MDU_WAIT, cnt!=0: same stall outputs as the mdu_start cycle; cnt decrements.
  - branch_taken, mdu_start and halt_req are ignored.
- MDU_WAIT, cnt==0: RUN default outputs, busy=0. Next state is RUN.
- Total frozen cycles per MDU op = MDU_LAT, including the start cycle.
- HALT: all *_write=0, all *_flush=0 (pipeline frozen, contents kept); halted=1.
  - resume=1 gives next state RUN and outputs the RUN default in that cycle.
  - resume and halt_req both high: resume wins.
- Reset asserted mid-MDU or in HALT aborts immediately to RUN with cnt=0.
- No counter wrap is possible: cnt never decrements below 0.

Optional Feature:
Macro STALL_COUNTER_EN.
- Defined: stall_cycles increments by 1 each cycle in which pc_write=0 and state!=HALT. It saturates at 16'hFFFF and clears only on reset.
- Undefined: stall_cycles is tied to 16'h0000 and no counter register is built.

Test Plan:
- Reset release, idle inputs -> from the first clk edge all writes=1, all flushes=0, busy=0, halted=0.
- ex_is_load=1, ex_rd=4'h3, id_rs2=4'h3, id_uses_rs2=1 for one cycle -> that cycle pc_write=0, ifid_write=0, idex_flush=1; the next cycle returns to normal. With STALL_COUNTER_EN, stall_cycles=1.
- MDU_LAT=4, mdu_start pulse -> pc_write=0 and busy=1 for exactly 4 cycles, then writes=1 on the 5th cycle. A branch_taken pulse injected during the wait is ignored.
- branch_taken=1 together with the load-use condition -> ifid_flush=1, idex_flush=1, pc_write=1; no stall follows.
- halt_req=1 -> halted=1 and all writes=0 from the next cycle. Holding for 10 cycles keeps stall_cycles unchanged; a resume pulse gives normal writes in the same cycle.
- rst driven low two cycles into an MDU wait (MDU_LAT=4) -> outputs immediately go to writes=0, flushes=1. After release the controller is in RUN with busy=0.
